mux_scan_ctrl: RTL
==================

# mux_scan_ctrl

Sequencer on the select side of the 8:1 6-bit result multiplexer in the ALU datapath. On a start request it steps the mux select through a masked subset of the eight result channels. For each channel it samples the mux output and presents the value downstream on a valid/ready stream. It also accumulates optional per-scan statistics: sum, maximum value and the channel holding the maximum.

## Interface
- No parameters. Channel count is fixed at 8, select width at 3 and data width at 6.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: scan request; sampled only in IDLE.
- `mask` input 8: channel enable; bit i set means channel i is scanned. Latched when `start` is accepted.
- `sel` output 3: registered select, drives the mux SEL input.
- `y_in` input 6: mux Y output, combinational from `sel`.
- `out_valid` output 1: result beat valid.
- `out_ready` input 1: downstream accepts the beat.
- `out_ch` output 3: channel index of the current beat.
- `out_data` output 6: sampled value of the current beat.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at scan completion.
- `sum` output 9: sum of the scanned values; maximum 8×63 = 504, so no overflow.
- `max_val` output 6: largest value scanned.
- `max_ch` output 3: channel index of `max_val`.

## Operation
- States: IDLE, SEL, OUT, FIN.
- IDLE:
  - `start`=1 latches `mask` into `mask_q`, clears `sum`/`max_val`/`max_ch` and sets `busy`.
  - If `mask`≠0: `sel` takes the lowest set channel index; go to SEL.
  - If `mask`=0: go to FIN; no beats are produced.
- SEL: `y_in` is sampled into `out_data`, `sel` is copied into `out_ch`, `out_valid` goes to 1 and the stats are updated; go to OUT.
- OUT: `out_valid`, `out_ch` and `out_data` are held stable until `out_valid`&&`out_ready`. On that handshake edge:
  - `out_valid` goes to 0.
  - If `mask_q` has a set bit above `out_ch`, `sel` takes the next higher set index; go to SEL.
  - Otherwise go to FIN.
- FIN: `done`=1 for exactly this cycle; next state is IDLE with `busy`=0.
- Channels are always scanned in ascending index order. Masked-off channels take no cycles.
- Stats update on the SEL capture edge:
  - `sum` += `y_in`, zero-extended to 9 bits.
  - If `y_in` > `max_val` (strict), or this is the first channel of the scan, `max_val` and `max_ch` are updated. On ties the lower channel index is kept.
- Stats and `sel` hold their values after the scan until the next accepted `start`.
- `start` outside IDLE is ignored and not queued. `mask` changes after acceptance have no effect.
- `sel` changes only on the edge that enters SEL, so `y_in` has a full cycle to settle before it is sampled.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE; `sel`=0, `out_valid`=0, `out_ch`=0, `out_data`=0, `busy`=0, `done`=0, `sum`=0, `max_val`=0, `max_ch`=0. Reset mid-scan aborts the scan with no `done` pulse; a pending beat is dropped.
- With `start` accepted at edge k: `busy` is 1 from k+1, `sel` is valid from k+1, and the first `out_valid` is 1 from k+2.
- Each channel costs 2 cycles with `out_ready` held at 1; each cycle of `out_ready`=0 adds one cycle.
- A full mask with `out_ready`=1 takes 16 cycles of SEL/OUT plus 1 cycle of FIN; `done` is high at cycle k+17.
- With an empty mask, `done` is high at cycle k+1.
- The last handshake and the FIN state are in consecutive cycles.
- `out_ready` is ignored while `out_valid`=0.

## Configuration
- `MUX_SCAN_STATS_EN`:
  - Defined: the `sum`/`max_val`/`max_ch` registers and logic are built as described above.
  - Undefined: the stats logic is omitted and the three outputs are tied to 0. Handshake and cycle timing are identical in both builds.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random inputs -> all outputs equal their reset values; `busy`=0.
- Full scan: mux inputs D0..D7 = 5,63,0,63,12,1,2,3; `mask`=8'hFF; `out_ready`=1 -> 8 beats with ch 0..7 and the matching values; `sum`=149, `max_val`=63, `max_ch`=1 (tie kept at the lower index); `done` at cycle k+17.
- Sparse mask with backpressure: `mask`=8'b1010_0100; `out_ready` low for 3 cycles on every beat -> beats only for ch 2, 5, 7; each beat is held stable while stalled; `sel` never visits 0, 1, 3, 4 or 6.
- Empty mask: `start` with `mask`=0 -> no `out_valid`; `done` at cycle k+1; stats are 0.
- Ignored start and reset abort: pulse `start` again mid-scan -> no effect. Assert `rst_n`=0 during OUT -> IDLE next cycle, no `done`; a new scan afterwards completes normally.
- Build without `MUX_SCAN_STATS_EN`: repeat the full-scan case -> identical beats and timing; `sum`/`max_val`/`max_ch` stay 0.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Select-side sequencer for the 8:1 x 6-bit result mux: scans masked channels, streams samples, keeps stats.
// Optional per-scan sum/max statistics are built only when MUX_SCAN_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; sel and stats hold the last scan's values
// SEL   | sel settled on a channel; y_in is captured at the end of this cycle
// OUT   | beat presented, waiting for out_ready
// FIN   | done pulse, scan complete
module mux_scan_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] mask,
    output logic [2:0] sel,
    input  logic [5:0] y_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_ch,
    output logic [5:0] out_data,
    output logic       busy,
    output logic       done,
    output logic [8:0] sum,
    output logic [5:0] max_val,
    output logic [2:0] max_ch
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEL, ST_OUT, ST_FIN} state_t;

    state_t     state_q, state_d;
    logic [7:0] mask_q, mask_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] out_ch_q, out_ch_d;
    logic [5:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;

    logic [7:0] pend;
    logic       nxt_found;
    logic [2:0] nxt_idx;
    logic       start_acc;
    logic       capture;

    // In IDLE the candidate set is the incoming mask; otherwise channels above the current beat.
    always_comb begin
        pend      = '0;
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = 0; i < 8; i++) begin
            if (state_q == ST_IDLE) begin
                pend[i] = mask[i];
            end else begin
                pend[i] = mask_q[i] && (3'(i) > out_ch_q);
            end
        end
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) begin
                nxt_found = 1'b1;
                nxt_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        sel_d       = sel_q;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        start_acc   = 1'b0;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    mask_d    = mask;
                    if (nxt_found) begin
                        sel_d   = nxt_idx;
                        state_d = ST_SEL;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_SEL: begin
                capture     = 1'b1;
                out_data_d  = y_in;
                out_ch_d    = sel_q;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (nxt_found) begin
                        sel_d   = nxt_idx;
                        state_d = ST_SEL;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            sel_q       <= '0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            sel_q       <= sel_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);

`ifdef MUX_SCAN_STATS_EN
    logic [8:0] sum_q, sum_d;
    logic [5:0] max_val_q, max_val_d;
    logic [2:0] max_ch_q, max_ch_d;
    logic       first_q, first_d;

    // Strict compare keeps the lower channel on ties; the first channel always seeds the max.
    always_comb begin
        sum_d     = sum_q;
        max_val_d = max_val_q;
        max_ch_d  = max_ch_q;
        first_d   = first_q;
        if (start_acc) begin
            sum_d     = '0;
            max_val_d = '0;
            max_ch_d  = '0;
            first_d   = 1'b1;
        end else if (capture) begin
            sum_d   = sum_q + {3'b000, y_in};
            first_d = 1'b0;
            if (first_q || (y_in > max_val_q)) begin
                max_val_d = y_in;
                max_ch_d  = sel_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q     <= '0;
            max_val_q <= '0;
            max_ch_q  <= '0;
            first_q   <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            max_val_q <= max_val_d;
            max_ch_q  <= max_ch_d;
            first_q   <= first_d;
        end
    end

    assign sum     = sum_q;
    assign max_val = max_val_q;
    assign max_ch  = max_ch_q;
`else
    assign sum     = '0;
    assign max_val = '0;
    assign max_ch  = '0;
`endif

endmodule
